// File: rtl/pc_redirect_ctrl.sv
// PC redirect control: turns E-stage branch / R15-write results into fetch/decode stall, flush and PC-mux selects.
// Optional perf counters (BrCnt, FlushCnt) exist only when COND_PERF_CNT_EN is defined.
module pc_redirect_ctrl #(
    parameter int PCW_DEPTH = 2
`ifdef COND_PERF_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             BranchTakenE,
    input  logic             LdStallD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             RedirectBrF,
    output logic             RedirectWbF,
`ifdef COND_PERF_CNT_EN
    output logic [CNT_W-1:0] BrCnt,
    output logic [CNT_W-1:0] FlushCnt,
`endif
    output logic             PendPCW
);

    typedef enum logic {RUN, PCWAIT} state_t;

    state_t               state_q, state_d;
    logic [PCW_DEPTH-1:0] pcw_q, pcw_d;
    logic [PCW_DEPTH-1:0] pcw_older;
    logic                 new_pcw;
    logic                 pcw_in_w;

    // A taken branch in E squashes a same-cycle R15 write from ever committing.
    assign new_pcw  = PCSrcE & ~BranchTakenE;
    assign pcw_in_w = pcw_q[PCW_DEPTH-1];

    always_comb begin
        pcw_d    = pcw_q << 1;
        pcw_d[0] = new_pcw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcw_q   <= '0;
            state_q <= RUN;
        end else begin
            pcw_q   <= pcw_d;
            state_q <= state_d;
        end
    end

    // Leave PCWAIT only once the last in-flight R15 write reaches W.
    always_comb begin
        pcw_older              = pcw_q;
        pcw_older[PCW_DEPTH-1] = 1'b0;
        state_d                = state_q;
        case (state_q)
            RUN:     if (new_pcw) state_d = PCWAIT;
            PCWAIT:  if (pcw_in_w && !new_pcw && (pcw_older == '0)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        RedirectBrF = 1'b0;
        RedirectWbF = 1'b0;
        PendPCW     = 1'b0;
        if (!reset) begin
            PendPCW = (|pcw_q) | (state_q == PCWAIT);
            if (BranchTakenE) begin
                RedirectBrF = 1'b1;
                FlushD      = 1'b1;
                FlushE      = 1'b1;
            end else begin
                FlushE = LdStallD;
                if (pcw_in_w) begin
                    RedirectWbF = 1'b1;
                    FlushD      = 1'b1;
                end else if (PCSrcD || PCSrcE || (state_q == PCWAIT)) begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                end else if (LdStallD) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                end
            end
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] brcnt_q, flushcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brcnt_q    <= '0;
            flushcnt_q <= '0;
        end else begin
            if (BranchTakenE && (brcnt_q != '1)) brcnt_q <= brcnt_q + CNT_W'(1);
            if (FlushD && (flushcnt_q != '1)) flushcnt_q <= flushcnt_q + CNT_W'(1);
        end
    end

    assign BrCnt    = brcnt_q;
    assign FlushCnt = flushcnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a queue scoreboard of expected output vectors.
module tb_pc_redirect_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic PCSrcD, PCSrcE, BranchTakenE, LdStallD;
    logic StallF, StallD, FlushD, FlushE, RedirectBrF, RedirectWbF, PendPCW;
`ifdef COND_PERF_CNT_EN
    logic [3:0] BrCnt, FlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected vector: {StallF, StallD, FlushD, FlushE, RedirectBrF, RedirectWbF, PendPCW}
    logic [6:0] exp_q[$];

    pc_redirect_ctrl #(
        .PCW_DEPTH(2)
`ifdef COND_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .PCSrcD(PCSrcD),
        .PCSrcE(PCSrcE),
        .BranchTakenE(BranchTakenE),
        .LdStallD(LdStallD),
        .StallF(StallF),
        .StallD(StallD),
        .FlushD(FlushD),
        .FlushE(FlushE),
        .RedirectBrF(RedirectBrF),
        .RedirectWbF(RedirectWbF),
`ifdef COND_PERF_CNT_EN
        .BrCnt(BrCnt),
        .FlushCnt(FlushCnt),
`endif
        .PendPCW(PendPCW)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {StallF, StallD, FlushD, FlushE, RedirectBrF, RedirectWbF, PendPCW};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check mid-cycle.
    task automatic step(input string tag, input logic pd, input logic pe, input logic br,
                        input logic ld, input logic [6:0] exp);
        @(negedge clk);
        PCSrcD       = pd;
        PCSrcE       = pe;
        BranchTakenE = br;
        LdStallD     = ld;
        exp_q.push_back(exp);
        #2;
        check_out(tag);
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; PCSrcD = 1'b0; PCSrcE = 1'b0; BranchTakenE = 1'b0; LdStallD = 1'b0;
        exp_q.push_back(7'b000_0000);
        #2;
        check_out("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
        step("idle",        0, 0, 0, 0, 7'b000_0000);

        // Taken branch for one cycle
        step("br_c0",       0, 0, 1, 0, 7'b001_1100);
        step("br_c1",       0, 0, 0, 0, 7'b000_0000);

        // PCSrcD then PCSrcE: stall until the write redirects from W
        step("pcw_c0",      1, 0, 0, 0, 7'b101_0000);
        step("pcw_c1",      0, 1, 0, 0, 7'b101_0000);
        step("pcw_c2",      0, 0, 0, 0, 7'b101_0001);
        step("pcw_c3",      0, 0, 0, 0, 7'b001_0011);
        step("pcw_c4",      0, 0, 0, 0, 7'b000_0000);

        // Back-to-back R15 writes
        step("b2b_c0",      0, 1, 0, 0, 7'b101_0000);
        step("b2b_c1",      0, 1, 0, 0, 7'b101_0001);
        step("b2b_c2",      0, 0, 0, 0, 7'b001_0011);
        step("b2b_c3",      0, 0, 0, 0, 7'b001_0011);
        step("b2b_c4",      0, 0, 0, 0, 7'b000_0000);

        // Branch beats load-use stall, then plain load-use stall
        step("ld_br",       0, 0, 1, 1, 7'b001_1100);
        step("ld_only",     0, 0, 0, 1, 7'b110_1000);
        step("ld_idle",     0, 0, 0, 0, 7'b000_0000);

        // R15 write squashed by a same-cycle taken branch never commits
        step("sq_c0",       0, 1, 1, 0, 7'b001_1100);
        step("sq_c1",       0, 0, 0, 0, 7'b000_0000);
        step("sq_c2",       0, 0, 0, 0, 7'b000_0000);

        // Load-use stall while an R15 write is pending
        step("pld_c0",      0, 1, 0, 1, 7'b101_1000);
        step("pld_c1",      0, 0, 0, 1, 7'b101_1001);
        step("pld_c2",      0, 0, 0, 0, 7'b001_0011);
        step("pld_c3",      0, 0, 0, 0, 7'b000_0000);

        // Reset asserted mid-cycle while in PCWAIT
        step("rst_c0",      0, 1, 0, 0, 7'b101_0000);
        step("rst_c1",      1, 0, 0, 0, 7'b101_0001);
        reset = 1'b1;
        exp_q.push_back(7'b000_0000);
        #1;
        check_out("rst_async");
        @(negedge clk);
        reset = 1'b0;
        PCSrcD = 1'b0;
        step("rst_run",     0, 0, 0, 0, 7'b000_0000);
        step("rst_run2",    0, 0, 0, 0, 7'b000_0000);

`ifdef COND_PERF_CNT_EN
        check_cnt("brcnt_init", BrCnt, 4'h0);
        check_cnt("flushcnt_init", FlushCnt, 4'h0);
        for (int i = 0; i < 20; i++) begin
            step("perf_br", 0, 0, 1, 0, 7'b001_1100);
            check_cnt("brcnt_run", BrCnt, (i > 15) ? 4'hF : 4'(i));
        end
        step("perf_idle",   0, 0, 0, 0, 7'b000_0000);
        check_cnt("brcnt_sat", BrCnt, 4'hF);
        check_cnt("flushcnt_sat", FlushCnt, 4'hF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
